rr4x4_seq_mult_ctrl: RTL and testbench

RR4X4_SEQ_MULT_CTRL -- requirements
Module: rr4x4_seq_mult_ctrl

---
 rtl/rr4x4_seq_mult_ctrl.sv | 141 ++++++++++++++
 tb/tb_rr4x4_seq_mult_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rr4x4_seq_mult_ctrl.sv
// rr4x4_seq_mult_ctrl
// Sequential 4x4 unsigned multiplier. The operands are split into a 1-bit high
// part and a 3-bit low part. A single shared 3x3 multiply unit produces one
// partial product per cycle over four PP steps, and each partial product is
// added into an 8-bit accumulator.
// The input and output sides each use a valid/ready handshake.
// Optional feature: define RR4X4_ZERO_SKIP_EN to make a zero operand bypass
// the PP steps and go straight to DONE with a zero product.
module rr4x4_seq_mult_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_p,
    output logic       busy,
    output logic [1:0] step
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PP   = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     r_state;
    logic [3:0] r_a;
    logic [3:0] r_b;
    logic [7:0] r_acc;
    logic [1:0] r_step;
    logic       r_in_ready;
    logic       r_out_valid;
    logic       r_busy;

    logic [2:0] w_mul_a;
    logic [2:0] w_mul_b;
    logic [5:0] w_pp;
    logic [7:0] w_pp_ext;
    logic [7:0] w_addend;
    logic       w_xfer;
`ifdef RR4X4_ZERO_SKIP_EN
    logic       w_zero_op;
`endif

    assign w_xfer = in_valid & r_in_ready;
`ifdef RR4X4_ZERO_SKIP_EN
    assign w_zero_op = (in_a == 4'd0) || (in_b == 4'd0);
`endif

    // Operand mux for the shared multiply unit.
    // step[1] selects A_H over A_L, and step[0] selects B_H over B_L.
    // The 1-bit high parts are zero-extended to 3 bits.
    always_comb begin
        w_mul_a = r_step[1] ? {2'b00, r_a[3]} : r_a[2:0];
        w_mul_b = r_step[0] ? {2'b00, r_b[3]} : r_b[2:0];
    end

    // Shared 3x3 multiply, then weight the partial product by its bit position.
    always_comb begin
        w_pp     = {3'b000, w_mul_a} * {3'b000, w_mul_b};
        w_pp_ext = {2'b00, w_pp};
        case (r_step)
            2'd0:    w_addend = w_pp_ext;
            2'd1:    w_addend = w_pp_ext << 3;
            2'd2:    w_addend = w_pp_ext << 3;
            default: w_addend = w_pp_ext << 6;
        endcase
    end

    // Control FSM, datapath registers and registered handshake/status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_step      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_xfer) begin
                        r_a        <= in_a;
                        r_b        <= in_b;
                        r_acc      <= '0;
                        r_step     <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
`ifdef RR4X4_ZERO_SKIP_EN
                        if (w_zero_op) begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= S_PP;
                        end
`else
                        r_state <= S_PP;
`endif
                    end
                end
                S_PP: begin
                    r_acc <= r_acc + w_addend;
                    if (r_step == 2'd3) begin
                        r_state     <= S_DONE;
                        r_step      <= '0;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_step <= r_step + 2'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_step      <= '0;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_p     = r_acc;
    assign busy      = r_busy;
    assign step      = r_step;

endmodule

// File: tb/tb_rr4x4_seq_mult_ctrl.sv
// Directed testbench for rr4x4_seq_mult_ctrl (default build, zero-skip disabled).
module tb_rr4x4_seq_mult_ctrl;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_p;
    logic       busy;
    logic [1:0] step;

    int checks;
    int errors;

    rr4x4_seq_mult_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .busy      (busy),
        .step      (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one operand pair for a single edge, then scramble the operand inputs.
    task automatic do_xfer(input logic [3:0] a, input logic [3:0] b);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a     = ~a;
        in_b     = ~b;
    endtask

    // Count the edges until out_valid rises, giving up after 20 edges.
    task automatic wait_valid(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
        #12;
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_p !== 8'h00)    begin errors++; $display("FAIL reset_out_p got %h want 00", out_p); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (step !== 2'd0)      begin errors++; $display("FAIL reset_step got %0d want 0", step); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_15x15();
        out_ready = 1'b1;
        do_xfer(4'd15, 4'd15);
        checks++; if (step !== 2'd0 || busy !== 1'b1 || in_ready !== 1'b0)
            begin errors++; $display("FAIL f15_after_xfer step=%0d busy=%b in_ready=%b want 0 1 0", step, busy, in_ready); end
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            checks++; if (step !== k[1:0] || out_valid !== 1'b0)
                begin errors++; $display("FAIL f15_step got %0d valid=%b want %0d 0", step, out_valid, k); end
        end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1 || out_p !== 8'hE1)
            begin errors++; $display("FAIL f15_result valid=%b p=%h want 1 e1", out_valid, out_p); end
        checks++; if (step !== 2'd0 || busy !== 1'b1)
            begin errors++; $display("FAIL f15_done_status step=%0d busy=%b want 0 1", step, busy); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
            begin errors++; $display("FAIL f15_return_idle valid=%b in_ready=%b busy=%b want 0 1 0", out_valid, in_ready, busy); end
    endtask

    task automatic test_backpressure();
        int n;
        out_ready = 1'b0;
        do_xfer(4'd9, 4'd5);
        // A request while busy must be ignored.
        in_valid = 1'b1; in_a = 4'd2; in_b = 4'd3;
        wait_valid(n);
        checks++; if (n != 4 || out_p !== 8'h2D)
            begin errors++; $display("FAIL bp_latency lat=%0d p=%h want 4 2d", n, out_p); end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1 || out_p !== 8'h2D || in_ready !== 1'b0)
                begin errors++; $display("FAIL bp_hold valid=%b p=%h in_ready=%b want 1 2d 0", out_valid, out_p, in_ready); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin errors++; $display("FAIL bp_release valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
        repeat (6) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("FAIL bp_no_queue valid=%b busy=%b want 0 0", out_valid, busy); end
    endtask

    task automatic test_8x8();
        int n;
        out_ready = 1'b1;
        do_xfer(4'd8, 4'd8);
        wait_valid(n);
        checks++; if (n != 4 || out_p !== 8'd64)
            begin errors++; $display("FAIL m8x8 lat=%0d p=%0d want 4 64", n, out_p); end
        @(posedge clk); #1;
    endtask

    task automatic test_zero();
        int n;
        out_ready = 1'b1;
        do_xfer(4'd0, 4'd13);
        wait_valid(n);
`ifdef RR4X4_ZERO_SKIP_EN
        checks++; if (n != 0 || out_p !== 8'd0)
            begin errors++; $display("FAIL zero_op lat=%0d p=%0d want 0 0", n, out_p); end
`else
        checks++; if (n != 4 || out_p !== 8'd0)
            begin errors++; $display("FAIL zero_op lat=%0d p=%0d want 4 0", n, out_p); end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort();
        int n;
        int seen;
        out_ready = 1'b1;
        do_xfer(4'd7, 4'd6);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (step !== 2'd2)
            begin errors++; $display("FAIL abort_at_step got %0d want 2", step); end
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_p !== 8'd0 || busy !== 1'b0 || step !== 2'd0)
            begin errors++; $display("FAIL abort_outputs rdy=%b v=%b p=%h busy=%b step=%0d want 1 0 00 0 0", in_ready, out_valid, out_p, busy, step); end
        @(posedge clk); #1;
        rst  = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        checks++; if (seen != 0)
            begin errors++; $display("FAIL abort_no_valid got %0d pulses want 0", seen); end
        do_xfer(4'd3, 4'd3);
        wait_valid(n);
        checks++; if (n != 4 || out_p !== 8'd9)
            begin errors++; $display("FAIL after_abort lat=%0d p=%0d want 4 9", n, out_p); end
        @(posedge clk); #1;
    endtask

    // Immediate transfer after reset release: in_valid is already high at the first edge.
    task automatic test_first_after_reset();
        int n;
        out_ready = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        do_xfer(4'd6, 4'd7);
        checks++; if (busy !== 1'b1)
            begin errors++; $display("FAIL first_edge_xfer busy=%b want 1", busy); end
        wait_valid(n);
        checks++; if (n != 4 || out_p !== 8'd42)
            begin errors++; $display("FAIL first_edge_result lat=%0d p=%0d want 4 42", n, out_p); end
        @(posedge clk); #1;
    endtask

    task automatic test_exhaustive();
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp_p;
        logic [7:0] got;
        int hs_total;
        int hs;
        int n;
        int bad_gap;
        hs_total  = 0;
        out_ready = 1'b0;
        for (int idx = 0; idx < 256; idx++) begin
            a       = idx[7:4];
            b       = idx[3:0];
            exp_p   = {4'b0000, a} * {4'b0000, b};
            bad_gap = 0;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
                if (out_valid !== 1'b0) bad_gap++;
            end
            checks++; if (bad_gap != 0 || in_ready !== 1'b1)
                begin errors++; $display("FAIL exh_idle a=%0d b=%0d stray=%0d in_ready=%b want 0 1", a, b, bad_gap, in_ready); end
            do_xfer(a, b);
            hs = 0;
            n  = 0;
            got = '0;
            while (hs == 0 && n < 40) begin
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid === 1'b1 && out_ready === 1'b1) begin
                    got = out_p;
                    hs  = 1;
                end
                @(posedge clk); #1;
                n++;
            end
            out_ready = 1'b0;
            hs_total += hs;
            checks++; if (hs != 1 || got !== exp_p)
                begin errors++; $display("FAIL exh_product a=%0d b=%0d hs=%0d got %0d want %0d", a, b, hs, got, exp_p); end
            checks++; if (out_valid !== 1'b0)
                begin errors++; $display("FAIL exh_dup a=%0d b=%0d out_valid=%b want 0", a, b, out_valid); end
        end
        checks++; if (hs_total != 256)
            begin errors++; $display("FAIL exh_count got %0d want 256", hs_total); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_15x15();
        test_backpressure();
        test_8x8();
        test_zero();
        test_reset_abort();
        test_first_after_reset();
        test_exhaustive();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
